// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer: hold-FSM encoding
// and the counter-width helper used to size the per-channel counters.
package debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } hold_state_e;

  // Width needed to count from 0 up to terminal inclusive.
  function automatic int cnt_width(input int terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchroniser, tick-qualified stability filter, and the
// IDLE/HELD/LONG_HELD hold FSM producing registered one-clk event pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 32,
  parameter int REPEAT_TICKS = 8,
  parameter int REPEAT_EN    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick_en,
  input  logic               btn_in,
  output logic               btn_level,
  output logic               btn_press,
  output logic               btn_release,
  output logic               btn_long,
  output logic               btn_repeat,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int SW = cnt_width(STABLE_TICKS);
  localparam int HW = cnt_width(LONG_TICKS);
  localparam int RW = cnt_width(REPEAT_TICKS);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST    = RW'(REPEAT_TICKS - 1);

  logic          sync_q1, sync_q2;
  logic [SW-1:0] stab_q;
  logic          differs, accept, rise, fall;

  hold_state_e   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          press_d, release_d, long_d, repeat_d;

  // tick_en is a bare one-clk strobe: every counter and the FSM advance only on
  // clk edges where it is high; there is no back-pressure on this path.
  assign differs = (sync_q2 != btn_level);
  assign accept  = tick_en && differs && (stab_q == STABLE_LAST);
  assign rise    = accept && !btn_level;
  assign fall    = accept && btn_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      stab_q    <= '0;
      btn_level <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
      if (tick_en) begin
        if (!differs || accept) stab_q <= '0;
        else                    stab_q <= stab_q + SW'(1);
        if (accept) btn_level <= ~btn_level;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (tick_en) begin
          if (hold_q == HOLD_LAST) begin
            state_d = LONG_HELD;
            rep_d   = '0;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      LONG_HELD: begin
        // The fall tick wins over a coinciding repeat slot.
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (tick_en) begin
          if (rep_q == REP_LAST) begin
            rep_d    = '0;
            repeat_d = (REPEAT_EN != 0);
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      rep_q       <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
      btn_repeat  <= repeat_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/button_debouncer_multi.sv
// N_CH independent debounced buttons with press/release/long/repeat pulses;
// fsm_state exposes each channel's hold-FSM state (2 bits per channel).
module button_debouncer_multi
  import debounce_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 32,
  parameter int REPEAT_TICKS = 8,
  parameter int REPEAT_EN    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick_en,
  input  logic [N_CH-1:0]         btn_in,
  output logic [N_CH-1:0]         btn_level,
  output logic [N_CH-1:0]         btn_press,
  output logic [N_CH-1:0]         btn_release,
  output logic [N_CH-1:0]         btn_long,
  output logic [N_CH-1:0]         btn_repeat,
  output logic [N_CH*STATE_W-1:0] fsm_state
);

  if (N_CH < 1 || STABLE_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1 ||
      (REPEAT_EN != 0 && REPEAT_EN != 1)) begin : g_param_check
    $error("button_debouncer_multi: parameter out of range");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .REPEAT_EN    (REPEAT_EN)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick_en     (tick_en),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i]),
      .btn_repeat  (btn_repeat[i]),
      .state_dbg   (fsm_state[i*STATE_W +: STATE_W])
    );
  end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Directed bench for button_debouncer_multi (N_CH=2, STABLE=4, LONG=8, REPEAT=3,
// tick_en every 4th clk); a second instance with REPEAT_EN=0 shares the stimulus.
module tb_button_debouncer_multi;

  logic       clk;
  logic       reset_n;
  logic       tick_en;
  logic [1:0] btn_in;
  logic [1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
  logic [3:0] fsm_state;
  logic [1:0] lvl2, press2, rel2, long2, rep2;
  logic [3:0] fsm2;

  button_debouncer_multi #(
    .N_CH(2), .STABLE_TICKS(4), .LONG_TICKS(8), .REPEAT_TICKS(3), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat), .fsm_state(fsm_state)
  );

  button_debouncer_multi #(
    .N_CH(2), .STABLE_TICKS(4), .LONG_TICKS(8), .REPEAT_TICKS(3), .REPEAT_EN(0)
  ) dut_norep (
    .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .btn_in(btn_in),
    .btn_level(lvl2), .btn_press(press2), .btn_release(rel2),
    .btn_long(long2), .btn_repeat(rep2), .fsm_state(fsm2)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;
  bit tick_on = 1'b1;
  bit was_tick;
  int tick_no = 0;
  int ev_base = 0;
  int cnt_press[2], cnt_rel[2], cnt_long[2], cnt_rep[2];
  int press_at[2], rel_at[2], long_at[2];
  int d2_long[2], d2_rep_seg, d2_rep_total;
  int excl_viol = 0;
  int lvl_changes = 0;
  logic [1:0] prev_level = 2'b00;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0] btn;
    int         n;
    logic [1:0] lvl;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } vec_t;
  vec_t vecs [22];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < 2; ch++) begin
      cnt_press[ch] = 0; cnt_rel[ch] = 0; cnt_long[ch] = 0; cnt_rep[ch] = 0;
      press_at[ch] = -1; rel_at[ch] = -1; long_at[ch] = -1; d2_long[ch] = 0;
    end
    d2_rep_seg  = 0;
    lvl_changes = 0;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    tick_en  = tick_on && (phase == 3);
    was_tick = tick_en;
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    if (was_tick) tick_no++;
    for (int ch = 0; ch < 2; ch++) begin
      int hits;
      hits = int'(btn_press[ch]) + int'(btn_release[ch]) + int'(btn_long[ch]) +
             int'(btn_repeat[ch]);
      if (hits > 1) excl_viol++;
      if (btn_press[ch])   begin cnt_press[ch]++; press_at[ch] = tick_no; end
      if (btn_release[ch]) begin cnt_rel[ch]++;   rel_at[ch]   = tick_no; end
      if (btn_long[ch])    begin cnt_long[ch]++;  long_at[ch]  = tick_no; end
      if (btn_repeat[ch]) begin
        cnt_rep[ch]++;
        if (exp_q.size() == 0) check("repeat_unexpected", tick_no - ev_base, -1);
        else                   check("repeat_tick", tick_no - ev_base, int'(exp_q.pop_front()));
      end
      if (long2[ch]) d2_long[ch]++;
      if (rep2[ch]) begin d2_rep_seg++; d2_rep_total++; end
    end
    if (btn_level !== prev_level) lvl_changes++;
    prev_level = btn_level;
  endtask

  task automatic wait_boundary();
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!was_tick && guard < 8);
    if (!was_tick) check("tick_boundary_timeout", 0, 1);
  endtask

  task automatic run_ticks(input int n);
    int target, guard;
    target = tick_no + n;
    guard  = 0;
    while (tick_no < target && guard < 4 * n + 8) begin
      step();
      guard++;
    end
    check("tick_budget", tick_no, target);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_n = 1'b0;
    tick_en = 1'b0;
    btn_in  = 2'b11;

    vecs[0]  = '{2'b01, 6, 2'b01, 2'b01, 2'b00, 2'b00};
    vecs[1]  = '{2'b00, 6, 2'b00, 2'b00, 2'b01, 2'b00};
    vecs[2]  = '{2'b10, 3, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 4; i < 14; i++)
      vecs[i] = '{((i % 2) == 0) ? 2'b11 : 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[14] = '{2'b00, 6, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[15] = '{2'b11, 4, 2'b11, 2'b11, 2'b00, 2'b00};
    vecs[16] = '{2'b01, 4, 2'b01, 2'b00, 2'b10, 2'b00};
    vecs[17] = '{2'b00, 4, 2'b00, 2'b00, 2'b01, 2'b00};
    vecs[18] = '{2'b01, 4, 2'b01, 2'b01, 2'b00, 2'b00};
    vecs[19] = '{2'b00, 2, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[20] = '{2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[21] = '{2'b00, 6, 2'b00, 2'b00, 2'b01, 2'b00};

    // Reset state, with buttons pressed while reset is held.
    clear_counts();
    repeat (6) step();
    check("reset_outputs", int'({btn_level, btn_press, btn_release, btn_long, btn_repeat}), 0);
    check("reset_fsm_state", int'(fsm_state), 0);
    btn_in = 2'b00;
    repeat (2) step();
    wait_boundary();
    reset_n = 1'b1;

    // Table-driven segments; each starts just after a tick edge.
    for (int i = 0; i < 22; i++) begin
      clear_counts();
      btn_in = vecs[i].btn;
      run_ticks(vecs[i].n);
      check($sformatf("v%0d_level", i), int'(btn_level), int'(vecs[i].lvl));
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("v%0d_press%0d", i, ch), cnt_press[ch], int'(vecs[i].press[ch]));
        check($sformatf("v%0d_release%0d", i, ch), cnt_rel[ch], int'(vecs[i].rel[ch]));
        check($sformatf("v%0d_long%0d", i, ch), cnt_long[ch], int'(vecs[i].lng[ch]));
        check($sformatf("v%0d_repeat%0d", i, ch), cnt_rep[ch], 0);
      end
    end

    // Clean press timing on ch0: press on the 4th tick after the change.
    clear_counts();
    ev_base = tick_no;
    btn_in  = 2'b01;
    run_ticks(5);
    check("clean_press_tick", press_at[0] - ev_base, 4);
    clear_counts();
    ev_base = tick_no;
    btn_in  = 2'b00;
    run_ticks(5);
    check("clean_release_tick", rel_at[0] - ev_base, 4);

    // Long press with auto-repeat on ch1; the fall lands on a repeat slot.
    clear_counts();
    ev_base = tick_no;
    exp_q = '{8'd15, 8'd18, 8'd21, 8'd24, 8'd27};
    btn_in = 2'b10;
    run_ticks(26);
    btn_in = 2'b00;
    run_ticks(6);
    check("long_press_tick", press_at[1] - ev_base, 4);
    check("long_long_tick", long_at[1] - ev_base, 12);
    check("long_release_tick", rel_at[1] - ev_base, 30);
    check("long_press_cnt", cnt_press[1], 1);
    check("long_long_cnt", cnt_long[1], 1);
    check("long_release_cnt", cnt_rel[1], 1);
    check("long_repeat_cnt", cnt_rep[1], 5);
    check("long_repeat_left", exp_q.size(), 0);
    check("long_ch0_quiet", cnt_press[0] + cnt_rel[0] + cnt_long[0], 0);
    check("norep_long_cnt", d2_long[1], 1);
    check("norep_repeat_cnt", d2_rep_seg, 0);

    // Reset asserted while ch0 is in LONG_HELD.
    clear_counts();
    btn_in = 2'b01;
    run_ticks(14);
    check("pre_reset_long", cnt_long[0], 1);
    check("pre_reset_state", int'(fsm_state), 2);
    clear_counts();
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", int'({btn_level, btn_press, btn_release, btn_long, btn_repeat}), 0);
    check("midreset_state", int'(fsm_state), 0);
    repeat (2) step();
    wait_boundary();
    check("midreset_no_release", cnt_rel[0], 0);
    reset_n = 1'b1;
    clear_counts();
    ev_base = tick_no;
    run_ticks(5);
    check("post_reset_press_tick", press_at[0] - ev_base, 4);
    check("post_reset_level", int'(btn_level), 1);
    clear_counts();
    btn_in = 2'b00;
    run_ticks(6);
    check("post_reset_release", cnt_rel[0], 1);
    check("post_reset_no_long", cnt_long[0], 0);

    // Frozen sampling: ch0 held, tick_en off, inputs wander for 100 clk.
    clear_counts();
    btn_in = 2'b01;
    run_ticks(4);
    check("freeze_press", cnt_press[0], 1);
    clear_counts();
    tick_on = 1'b0;
    for (int i = 0; i < 100; i++) begin
      btn_in = 2'($urandom_range(0, 3));
      step();
    end
    btn_in = 2'b01;
    repeat (3) step();
    check("freeze_level_changes", lvl_changes, 0);
    check("freeze_pulses", cnt_press[0] + cnt_press[1] + cnt_rel[0] + cnt_rel[1] +
          cnt_long[0] + cnt_long[1] + cnt_rep[0] + cnt_rep[1], 0);
    check("freeze_state", int'(fsm_state), 1);
    tick_on = 1'b1;
    wait_boundary();
    clear_counts();
    btn_in = 2'b00;
    run_ticks(6);
    check("unfreeze_release", cnt_rel[0], 1);
    check("unfreeze_no_long", cnt_long[0], 0);

    // ---------------- report ----------------
    check("exclusive_pulses", excl_viol, 0);
    check("norep_repeat_total", d2_rep_total, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
